// File: rtl/pop_scanner_if.sv
// Bus bundle between the population scanner, the population/fitness memories
// and the best-individual tracker.
interface pop_scanner_if #(
  parameter int FITNESS_WIDTH = 27,
  parameter int CHROM_WIDTH   = 8,
  parameter int ADDR_WIDTH    = 4
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     best_reset;
  logic                     rd_en;
  logic [ADDR_WIDTH-1:0]    rd_addr1;
  logic [ADDR_WIDTH-1:0]    rd_addr2;
  logic [FITNESS_WIDTH-1:0] fit_rd1;
  logic [FITNESS_WIDTH-1:0] fit_rd2;
  logic [CHROM_WIDTH-1:0]   chrom_rd1;
  logic [CHROM_WIDTH-1:0]   chrom_rd2;
  logic [FITNESS_WIDTH-1:0] fitness1;
  logic [FITNESS_WIDTH-1:0] fitness2;
  logic [CHROM_WIDTH-1:0]   chrom1;
  logic [CHROM_WIDTH-1:0]   chrom2;
  logic                     enable_second;

  modport master (
    input  start, fit_rd1, fit_rd2, chrom_rd1, chrom_rd2,
    output busy, done, best_reset, rd_en, rd_addr1, rd_addr2,
           fitness1, fitness2, chrom1, chrom2, enable_second
  );

  modport slave (
    output start, fit_rd1, fit_rd2, chrom_rd1, chrom_rd2,
    input  busy, done, best_reset, rd_en, rd_addr1, rd_addr2,
           fitness1, fitness2, chrom1, chrom2, enable_second
  );
endinterface

// File: rtl/pop_scanner.sv
// Scans the population two individuals per cycle and streams each pair into the
// best-individual tracker; done pulses once the tracker has sampled the last pair.
module pop_scanner #(
  parameter int FITNESS_WIDTH = 27,
  parameter int CHROM_WIDTH   = 8,
  parameter int POP_SIZE      = 16,
  parameter int ADDR_WIDTH    = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1
) (
  input  logic           clk,
  input  logic           reset,
  pop_scanner_if.master  bus
);

  localparam int NUM_PAIRS = (POP_SIZE + 1) / 2;
  localparam int CNT_WIDTH = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_PAIR = CNT_WIDTH'(NUM_PAIRS - 1);
  localparam bit ODD_POP = (POP_SIZE % 2) == 1;
  localparam logic [FITNESS_WIDTH-1:0] FIT_IDLE = '1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   pair_reg, pair_next;
  logic                   drain_reg, drain_next;
  logic                   rd_en;
  logic                   last_single;
  logic [CNT_WIDTH:0]     addr1_full;
  logic [CNT_WIDTH:0]     addr2_full;
  logic                   valid_reg;
  logic                   tag_reg;
  logic                   enable_second_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pair_reg  <= '0;
      drain_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pair_reg  <= pair_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pair_next  = pair_reg;
    drain_next = drain_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        pair_next  = '0;
        state_next = READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (pair_reg == LAST_PAIR) begin
          drain_next = 1'b0;
          state_next = DRAIN;
        end else begin
          pair_next = pair_reg + CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_reg) begin
          state_next = DONE;
        end else begin
          drain_next = 1'b1;
        end
      end
      DONE: begin
        // A start still held here chains straight into the next scan.
        state_next = bus.start ? CLEAR : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The final pair of an odd population has no partner: read the same slot twice.
  assign last_single = ODD_POP && (pair_reg == LAST_PAIR);
  assign addr1_full  = {pair_reg, 1'b0};
  assign addr2_full  = last_single ? addr1_full : {pair_reg, 1'b1};

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr1   = rd_en ? addr1_full[ADDR_WIDTH-1:0] : '0;
  assign bus.rd_addr2   = rd_en ? addr2_full[ADDR_WIDTH-1:0] : '0;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);
  assign bus.best_reset = (state_reg == CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg         <= 1'b0;
      tag_reg           <= 1'b0;
      enable_second_reg <= 1'b0;
    end else begin
      valid_reg         <= rd_en;
      tag_reg           <= rd_en & ~last_single;
      enable_second_reg <= valid_reg & tag_reg;
    end
  end

  logic [FITNESS_WIDTH-1:0] fit_in   [2];
  logic [CHROM_WIDTH-1:0]   chrom_in [2];

  assign fit_in[0]   = bus.fit_rd1;
  assign fit_in[1]   = bus.fit_rd2;
  assign chrom_in[0] = bus.chrom_rd1;
  assign chrom_in[1] = bus.chrom_rd2;

  // Output slots hold the idle value (worst fitness) unless a real individual is present.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    localparam bit ALWAYS_LIVE = (gi == 0);
    logic                     live;
    logic [FITNESS_WIDTH-1:0] fit_reg;
    logic [CHROM_WIDTH-1:0]   chrom_reg;

    assign live = valid_reg & (ALWAYS_LIVE | tag_reg);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fit_reg   <= FIT_IDLE;
        chrom_reg <= '0;
      end else if (live) begin
        fit_reg   <= fit_in[gi];
        chrom_reg <= chrom_in[gi];
      end else begin
        fit_reg   <= FIT_IDLE;
        chrom_reg <= '0;
      end
    end
  end

  assign bus.fitness1      = g_slot[0].fit_reg;
  assign bus.fitness2      = g_slot[1].fit_reg;
  assign bus.chrom1        = g_slot[0].chrom_reg;
  assign bus.chrom2        = g_slot[1].chrom_reg;
  assign bus.enable_second = enable_second_reg;

endmodule

// File: tb/tb_pop_scanner.sv
// Scoreboard bench: four scanners (POP_SIZE 16, 5, 4, 1) exercised one at a time;
// stimulus queues expected events, a negedge monitor pops and compares them.
module tb_pop_scanner;

  localparam int NI = 4;
  localparam logic [26:0] ONES = '1;
  localparam int K_BUSY = 0, K_CLR = 1, K_RD = 2, K_OUT = 3, K_DONE = 4;
  localparam int R_RST = 0, R_BEST = 1, R_TIMEOUT = 2;

  function automatic int size_of(input int i);
    case (i)
      0: return 16;
      1: return 5;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0]  inst;
    logic [2:0]  kind;
    logic [31:0] cyc;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [26:0] f1;
    logic [26:0] f2;
    logic [7:0]  c1;
    logic [7:0]  c2;
    logic        es;
  } ev_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  inst;
    logic [26:0] val;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]        rst_v;
  logic [NI-1:0]        start_v;
  logic [NI-1:0]        busy_v, done_v, br_v, rden_v, es_v;
  logic [NI-1:0][3:0]   a1_v, a2_v;
  logic [NI-1:0][26:0]  f1_v, f2_v;
  logic [NI-1:0][7:0]   c1_v, c2_v;

  logic [26:0] fit_mem   [NI][16];
  logic [7:0]  chrom_mem [NI][16];

  ev_t  exp_q [$];
  req_t chk_q [$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int P  = size_of(gi);
    localparam int AW = (P > 1) ? $clog2(P) : 1;

    pop_scanner_if #(.FITNESS_WIDTH(27), .CHROM_WIDTH(8), .ADDR_WIDTH(AW)) bus ();

    pop_scanner #(
      .FITNESS_WIDTH(27), .CHROM_WIDTH(8), .POP_SIZE(P), .ADDR_WIDTH(AW)
    ) dut (
      .clk   (clk),
      .reset (rst_v[gi]),
      .bus   (bus)
    );

    assign bus.start = start_v[gi];

    always @(posedge clk) begin
      if (bus.rd_en) begin
        bus.fit_rd1   <= fit_mem[gi][bus.rd_addr1];
        bus.fit_rd2   <= fit_mem[gi][bus.rd_addr2];
        bus.chrom_rd1 <= chrom_mem[gi][bus.rd_addr1];
        bus.chrom_rd2 <= chrom_mem[gi][bus.rd_addr2];
      end
    end

    assign busy_v[gi] = bus.busy;
    assign done_v[gi] = bus.done;
    assign br_v[gi]   = bus.best_reset;
    assign rden_v[gi] = bus.rd_en;
    assign es_v[gi]   = bus.enable_second;
    assign a1_v[gi]   = 4'(bus.rd_addr1);
    assign a2_v[gi]   = 4'(bus.rd_addr2);
    assign f1_v[gi]   = bus.fitness1;
    assign f2_v[gi]   = bus.fitness2;
    assign c1_v[gi]   = bus.chrom1;
    assign c2_v[gi]   = bus.chrom2;
  end

  // Strict less-than tracker attached to the POP_SIZE=5 scanner.
  logic [26:0] trk_best, trk_cand;
  always_comb begin
    trk_cand = trk_best;
    if (f1_v[1] < trk_cand) trk_cand = f1_v[1];
    if (es_v[1] && (f2_v[1] < trk_cand)) trk_cand = f2_v[1];
  end
  always @(posedge clk) begin
    if (br_v[1]) trk_best <= ONES;
    else         trk_best <= trk_cand;
  end

  function automatic string kname(input logic [2:0] k);
    case (k)
      3'd0: return "busy";
      3'd1: return "best_reset";
      3'd2: return "rd";
      3'd3: return "out";
      3'd4: return "done";
      default: return "?";
    endcase
  endfunction

  function automatic ev_t base_ev(input int inst, input int c, input int kind);
    ev_t e;
    e = '0;
    e.inst = 2'(inst);
    e.cyc  = 32'(c);
    e.kind = 3'(kind);
    return e;
  endfunction

  // Expected event stream of one scan whose start is high in cycle s.
  task automatic expect_scan(input int inst, input int s, input int stop);
    int p, np, j;
    ev_t e;
    p  = size_of(inst);
    np = (p + 1) / 2;
    for (int c = s + 1; c <= s + np + 4 && c < stop; c++) begin
      exp_q.push_back(base_ev(inst, c, K_BUSY));
      if (c == s + 1) exp_q.push_back(base_ev(inst, c, K_CLR));
      if (c >= s + 2 && c <= s + np + 1) begin
        j = c - s - 2;
        e = base_ev(inst, c, K_RD);
        e.a1 = 4'(2 * j);
        e.a2 = 4'((2 * j + 1 < p) ? 2 * j + 1 : 2 * j);
        exp_q.push_back(e);
      end
      if (c >= s + 4 && c <= s + np + 3) begin
        j = c - s - 4;
        e = base_ev(inst, c, K_OUT);
        e.f1 = fit_mem[inst][2 * j];
        e.c1 = chrom_mem[inst][2 * j];
        if (2 * j + 1 < p) begin
          e.f2 = fit_mem[inst][2 * j + 1];
          e.c2 = chrom_mem[inst][2 * j + 1];
          e.es = 1'b1;
        end else begin
          e.f2 = ONES;
        end
        exp_q.push_back(e);
      end
      if (c == s + np + 4) exp_q.push_back(base_ev(inst, c, K_DONE));
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t    act, e;
    logic   present;
    req_t   r;
    logic [103:0] got_v, want_v;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 5; k++) begin
        act = base_ev(i, cyc, k);
        present = 1'b0;
        case (k)
          K_BUSY: present = busy_v[i];
          K_CLR:  present = br_v[i];
          K_RD: begin
            present = rden_v[i];
            act.a1 = a1_v[i];
            act.a2 = a2_v[i];
          end
          K_OUT: begin
            present = (f1_v[i] != ONES) || (f2_v[i] != ONES) || es_v[i];
            act.f1 = f1_v[i];
            act.f2 = f2_v[i];
            act.c1 = c1_v[i];
            act.c2 = c2_v[i];
            act.es = es_v[i];
          end
          default: present = done_v[i];
        endcase
        if (present) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s inst=%0d cyc=%0d: got event, required none", kname(act.kind), i, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
              $display("FAIL %s inst=%0d cyc=%0d: got a=%0d,%0d f=%0d,%0d c=%0h,%0h es=%0b; required %s inst=%0d cyc=%0d a=%0d,%0d f=%0d,%0d c=%0h,%0h es=%0b",
                       kname(act.kind), i, cyc, act.a1, act.a2, act.f1, act.f2, act.c1, act.c2, act.es,
                       kname(e.kind), e.inst, e.cyc, e.a1, e.a2, e.f1, e.f2, e.c1, e.c2, e.es);
            end else begin
              pass_cnt++;
              $display("ok %s inst=%0d cyc=%0d", kname(act.kind), i, cyc);
            end
          end
        end
      end
    end
    while (chk_q.size() > 0) begin
      r = chk_q.pop_front();
      total_cnt++;
      case (int'(r.kind))
        R_RST: begin
          got_v  = {busy_v[r.inst], done_v[r.inst], br_v[r.inst], rden_v[r.inst], es_v[r.inst],
                    a1_v[r.inst], a2_v[r.inst], c1_v[r.inst], c2_v[r.inst], f1_v[r.inst], f2_v[r.inst], 3'b0};
          want_v = {5'b0, 4'd0, 4'd0, 8'd0, 8'd0, ONES, ONES, 3'b0};
          if (got_v !== want_v) $display("FAIL reset_values inst=%0d cyc=%0d: got %h required %h", r.inst, cyc, got_v, want_v);
          else begin pass_cnt++; $display("ok reset_values inst=%0d cyc=%0d", r.inst, cyc); end
        end
        R_BEST: begin
          if (trk_best !== r.val) $display("FAIL tracker_best cyc=%0d: got %0d required %0d", cyc, trk_best, r.val);
          else begin pass_cnt++; $display("ok tracker_best=%0d cyc=%0d", trk_best, cyc); end
        end
        default: begin
          $display("FAIL timeout inst=%0d cyc=%0d: got %0d pending events required 0", r.inst, cyc, r.val);
        end
      endcase
    end
  end

  task automatic request(input int kind, input int inst, input logic [26:0] val);
    req_t r;
    r.kind = 2'(kind);
    r.inst = 2'(inst);
    r.val  = val;
    chk_q.push_back(r);
  endtask

  task automatic wait_drain(input int inst);
    for (int n = 0; n < 80 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) begin
      request(R_TIMEOUT, inst, 27'(exp_q.size()));
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic scan(input int inst);
    int s;
    @(negedge clk);
    s = cyc;
    expect_scan(inst, s, s + 1000);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    wait_drain(inst);
  endtask

  initial begin
    int s;
    rst_v   = '1;
    start_v = '0;
    for (int i = 0; i < 16; i++) begin
      fit_mem[0][i]   = 27'(200 - 7 * i);
      chrom_mem[0][i] = 8'(9 * i + 1);
      for (int n = 1; n < NI; n++) begin
        fit_mem[n][i]   = 27'd999;
        chrom_mem[n][i] = 8'h00;
      end
    end
    fit_mem[1][0] = 27'd9; fit_mem[1][1] = 27'd7; fit_mem[1][2] = 27'd3;
    fit_mem[1][3] = 27'd8; fit_mem[1][4] = 27'd4;
    chrom_mem[1][0] = 8'h11; chrom_mem[1][1] = 8'h22; chrom_mem[1][2] = 8'h33;
    chrom_mem[1][3] = 8'h44; chrom_mem[1][4] = 8'h55;
    fit_mem[2][0] = 27'd40; fit_mem[2][1] = 27'd30; fit_mem[2][2] = 27'd20; fit_mem[2][3] = 27'd10;
    chrom_mem[2][0] = 8'ha0; chrom_mem[2][1] = 8'ha1; chrom_mem[2][2] = 8'ha2; chrom_mem[2][3] = 8'ha3;
    fit_mem[3][0] = 27'd5; chrom_mem[3][0] = 8'h5a;

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) request(R_RST, i, '0);
    @(negedge clk);
    rst_v = '0;
    repeat (2) @(negedge clk);

    // POP_SIZE=16: full scan, done 12 cycles after start
    scan(0);

    // POP_SIZE=5: odd tail pair, tracker ends at 3
    scan(1);
    request(R_BEST, 1, 27'd3);
    repeat (2) @(negedge clk);

    // Reset in cycle 6 of a POP_SIZE=16 scan, then a clean rescan
    @(negedge clk);
    s = cyc;
    expect_scan(0, s, s + 6);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (cyc < s + 5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_v[0] = 1'b1;
    request(R_RST, 0, '0);
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0;
    wait_drain(0);
    scan(0);

    // POP_SIZE=4 with start held 20 cycles: back-to-back scans every 6 cycles
    @(negedge clk);
    s = cyc;
    for (int k = 0; k < 4; k++) expect_scan(2, s + 6 * k, s + 1000);
    start_v[2] = 1'b1;
    repeat (20) @(negedge clk);
    start_v[2] = 1'b0;
    wait_drain(2);

    // POP_SIZE=1: single read at (0,0), done 5 cycles after start
    scan(3);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
